// File: rtl/minmax_tracker_pkg.sv
// ---------------------------------------------------------------------------
// minmax_tracker_pkg
// Shared types and constants for the min/max window tracker.
//   state_t    : tracker state (IDLE / ACCUM / DONE)
//   CNT_W      : width of the sample counter and of the position indices
//   WINDOW_MAX : largest window length the 8-bit counter can represent
// ---------------------------------------------------------------------------
package minmax_tracker_pkg;

    localparam int CNT_W      = 8;
    localparam int WINDOW_MAX = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : minmax_tracker_pkg

// File: rtl/minmax_tracker_if.sv
// ---------------------------------------------------------------------------
// minmax_tracker_if
// Sample-in / result-out handshake bundle for minmax_tracker.
//   in_valid, in_data, in_ready : sample stream (valid/ready)
//   flush                       : close a partial window early
//   res_valid, res_ready        : result handshake
//   res_min, res_max            : smallest / largest sample of the window
//   res_eq                      : all samples of the window were equal
//   res_count                   : number of samples in the window
//   res_min_idx, res_max_idx    : first position of min / max
//                                 (only with MINMAX_TRACKER_INDEX_EN defined)
// Modports: slave = the tracker, master = the producer/consumer side.
// ---------------------------------------------------------------------------
interface minmax_tracker_if
    import minmax_tracker_pkg::*;
#(
    parameter int wordsize = 16
);

    logic                in_valid;
    logic [wordsize-1:0] in_data;
    logic                in_ready;
    logic                flush;
    logic                res_valid;
    logic                res_ready;
    logic [wordsize-1:0] res_min;
    logic [wordsize-1:0] res_max;
    logic                res_eq;
    logic [CNT_W-1:0]    res_count;
`ifdef MINMAX_TRACKER_INDEX_EN
    logic [CNT_W-1:0]    res_min_idx;
    logic [CNT_W-1:0]    res_max_idx;
`endif

    modport slave (
        input  in_valid, in_data, flush, res_ready,
        output in_ready, res_valid, res_min, res_max, res_eq, res_count
`ifdef MINMAX_TRACKER_INDEX_EN
        , output res_min_idx, res_max_idx
`endif
    );

    modport master (
        output in_valid, in_data, flush, res_ready,
        input  in_ready, res_valid, res_min, res_max, res_eq, res_count
`ifdef MINMAX_TRACKER_INDEX_EN
        , input res_min_idx, res_max_idx
`endif
    );

endinterface : minmax_tracker_if

// File: rtl/minmax_tracker_cmp2.sv
// ---------------------------------------------------------------------------
// mm_cmp2
// Combinational unsigned compare of an incoming sample against the running
// minimum and maximum.
//   in_data : incoming sample
//   cur_min : running minimum
//   cur_max : running maximum
//   lt_min  : in_data <  cur_min (strict, so ties keep the stored value)
//   gt_max  : in_data >  cur_max (strict, so ties keep the stored value)
// ---------------------------------------------------------------------------
module mm_cmp2 #(
    parameter int wordsize = 16
) (
    input  logic [wordsize-1:0] in_data,
    input  logic [wordsize-1:0] cur_min,
    input  logic [wordsize-1:0] cur_max,
    output logic                lt_min,
    output logic                gt_max
);

    assign lt_min = (in_data < cur_min);
    assign gt_max = (in_data > cur_max);

endmodule : mm_cmp2

// File: rtl/minmax_tracker.sv
// ---------------------------------------------------------------------------
// minmax_tracker
// Collects up to `window` unsigned samples, then presents the smallest and
// largest sample, an all-equal flag and the sample count until the consumer
// takes the result. A flush closes a partial window early.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : minmax_tracker_if.slave (sample stream, flush, result handshake)
//
// Build option: MINMAX_TRACKER_INDEX_EN adds res_min_idx / res_max_idx, the
// 0-based position of the first occurrence of the min and max.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no samples held, ready for the first one
// ACCUM | 1..window-1 samples held, ready for more
// DONE  | result presented, input stalled until taken
// ---------------------------------------------------------------------------
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int window   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    minmax_tracker_if.slave     bus
);

    if (window < 1 || window > WINDOW_MAX) begin : g_bad_window
        $error("minmax_tracker: window must be in 1..%0d", WINDOW_MAX);
    end

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(window);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [wordsize-1:0] r_min;
    logic [wordsize-1:0] r_max;
    logic [wordsize-1:0] w_min_nxt;
    logic [wordsize-1:0] w_max_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_accept;
    logic                w_lt_min;
    logic                w_gt_max;
    logic                w_res_valid;
`ifdef MINMAX_TRACKER_INDEX_EN
    logic [CNT_W-1:0]    r_min_idx;
    logic [CNT_W-1:0]    r_max_idx;
    logic [CNT_W-1:0]    w_min_idx_nxt;
    logic [CNT_W-1:0]    w_max_idx_nxt;
`endif

    mm_cmp2 #(
        .wordsize (wordsize)
    ) u_cmp (
        .in_data (bus.in_data),
        .cur_min (r_min),
        .cur_max (r_max),
        .lt_min  (w_lt_min),
        .gt_max  (w_gt_max)
    );

    assign w_accept    = bus.in_valid && (r_state != DONE);
    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_min     <= '0;
            r_max     <= '0;
            r_count   <= '0;
`ifdef MINMAX_TRACKER_INDEX_EN
            r_min_idx <= '0;
            r_max_idx <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_min     <= w_min_nxt;
            r_max     <= w_max_nxt;
            r_count   <= w_count_nxt;
`ifdef MINMAX_TRACKER_INDEX_EN
            r_min_idx <= w_min_idx_nxt;
            r_max_idx <= w_max_idx_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_min_nxt     = r_min;
        w_max_nxt     = r_max;
        w_count_nxt   = r_count;
`ifdef MINMAX_TRACKER_INDEX_EN
        w_min_idx_nxt = r_min_idx;
        w_max_idx_nxt = r_max_idx;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_min_nxt   = bus.in_data;
                    w_max_nxt   = bus.in_data;
                    w_count_nxt = CNT_W'(1);
`ifdef MINMAX_TRACKER_INDEX_EN
                    w_min_idx_nxt = '0;
                    w_max_idx_nxt = '0;
`endif
                    // flush alongside the first sample closes a 1-sample window
                    if (WIN_CNT == CNT_W'(1) || bus.flush) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (w_lt_min) begin
                        w_min_nxt = bus.in_data;
`ifdef MINMAX_TRACKER_INDEX_EN
                        // r_count is the 0-based position of this sample
                        w_min_idx_nxt = r_count;
`endif
                    end
                    if (w_gt_max) begin
                        w_max_nxt = bus.in_data;
`ifdef MINMAX_TRACKER_INDEX_EN
                        w_max_idx_nxt = r_count;
`endif
                    end
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == WIN_CNT || bus.flush) begin
                        w_state_nxt = DONE;
                    end
                end else if (bus.flush) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    w_state_nxt = IDLE;
                    w_min_nxt   = '0;
                    w_max_nxt   = '0;
                    w_count_nxt = '0;
`ifdef MINMAX_TRACKER_INDEX_EN
                    w_min_idx_nxt = '0;
                    w_max_idx_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Result fields are forced to zero outside DONE so the consumer never
    // sees a partially accumulated window.
    assign w_res_valid   = (r_state == DONE);
    assign bus.in_ready  = (r_state != DONE);
    assign bus.res_valid = w_res_valid;
    assign bus.res_min   = w_res_valid ? r_min   : '0;
    assign bus.res_max   = w_res_valid ? r_max   : '0;
    assign bus.res_count = w_res_valid ? r_count : '0;
    assign bus.res_eq    = w_res_valid && (r_min == r_max);
`ifdef MINMAX_TRACKER_INDEX_EN
    assign bus.res_min_idx = w_res_valid ? r_min_idx : '0;
    assign bus.res_max_idx = w_res_valid ? r_max_idx : '0;
`endif

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// ---------------------------------------------------------------------------
// tb_minmax_tracker
// Directed scenarios followed by random traffic for minmax_tracker
// (wordsize = 16, window = 4). The reference model keeps the accepted samples
// of the open window in a queue and derives the result from that list.
// ---------------------------------------------------------------------------
module tb_minmax_tracker;

    localparam int WS  = 16;
    localparam int WIN = 4;

    logic clk;
    logic rst_n;

    minmax_tracker_if #(.wordsize(WS)) u_if ();

    minmax_tracker #(
        .wordsize (WS),
        .window   (WIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int       q[$];
    bit       m_done;
    int       e_min, e_max, e_cnt, e_min_idx, e_max_idx;
    bit       e_eq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void close_window();
        e_cnt     = q.size();
        e_min     = q[0];
        e_max     = q[0];
        e_min_idx = 0;
        e_max_idx = 0;
        foreach (q[i]) begin
            if (q[i] < e_min) begin e_min = q[i]; e_min_idx = i; end
            if (q[i] > e_max) begin e_max = q[i]; e_max_idx = i; end
        end
        e_eq = 1'b1;
        foreach (q[i]) if (q[i] != q[0]) e_eq = 1'b0;
        m_done = 1'b1;
        q.delete();
    endfunction

    // One clock: update the model with the inputs seen at the rising edge,
    // then compare every output at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            if (u_if.res_ready) m_done = 1'b0;
        end else begin
            if (u_if.in_valid) q.push_back(int'(u_if.in_data));
            if (q.size() == WIN || (u_if.flush && q.size() > 0)) close_window();
        end
        @(negedge clk);
        chk("in_ready",  u_if.in_ready,  32'(!m_done));
        chk("res_valid", u_if.res_valid, 32'(m_done));
        chk("res_min",   u_if.res_min,   m_done ? 32'(e_min) : 32'd0);
        chk("res_max",   u_if.res_max,   m_done ? 32'(e_max) : 32'd0);
        chk("res_eq",    u_if.res_eq,    m_done ? 32'(e_eq)  : 32'd0);
        chk("res_count", u_if.res_count, m_done ? 32'(e_cnt) : 32'd0);
`ifdef MINMAX_TRACKER_INDEX_EN
        chk("res_min_idx", u_if.res_min_idx, m_done ? 32'(e_min_idx) : 32'd0);
        chk("res_max_idx", u_if.res_max_idx, m_done ? 32'(e_max_idx) : 32'd0);
`endif
    endtask

    task automatic send(input logic [WS-1:0] d, input logic fl = 1'b0);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.flush    = fl;
        cycle();
        u_if.in_valid = 1'b0;
        u_if.flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        u_if.in_valid = 1'b0;
        u_if.flush    = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_res(input string tag, input int mn, input int mx, input int eq, input int cnt);
        chk({tag, "_valid"}, u_if.res_valid, 32'd1);
        chk({tag, "_min"},   u_if.res_min,   32'(mn));
        chk({tag, "_max"},   u_if.res_max,   32'(mx));
        chk({tag, "_eq"},    u_if.res_eq,    32'(eq));
        chk({tag, "_count"}, u_if.res_count, 32'(cnt));
    endtask

    initial begin
        m_done         = 1'b0;
        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.flush     = 1'b0;
        u_if.res_ready = 1'b1;

        // reset
        cycle();
        cycle();
        chk("rst_in_ready",  u_if.in_ready,  32'd1);
        chk("rst_res_valid", u_if.res_valid, 32'd0);
        chk("rst_res_count", u_if.res_count, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // basic window
        send(16'd5); send(16'd9); send(16'd2);
        chk("basic_pre_valid", u_if.res_valid, 32'd0);
        send(16'd7);
        chk_res("basic", 2, 9, 0, 4);
        idle(1);

        // all equal
        send(16'd3); send(16'd3); send(16'd3); send(16'd3);
        chk_res("equal", 3, 3, 1, 4);
`ifdef MINMAX_TRACKER_INDEX_EN
        chk("equal_min_idx", u_if.res_min_idx, 32'd0);
        chk("equal_max_idx", u_if.res_max_idx, 32'd0);
`endif
        idle(1);

        // flush together with the third sample
        send(16'd10); send(16'd4); send(16'd12, 1'b1);
        chk_res("flush", 4, 12, 0, 3);
        idle(1);

        // flush in ACCUM without a sample
        send(16'd20);
        u_if.flush = 1'b1;
        cycle();
        u_if.flush = 1'b0;
        chk_res("flush_only", 20, 20, 1, 1);
        idle(1);

        // back-pressure: result held, input stalled, stray samples not taken
        u_if.res_ready = 1'b0;
        send(16'd50); send(16'd60); send(16'd55); send(16'd51);
        for (int i = 0; i < 5; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = (i % 2 == 0) ? 16'h00AA : 16'h5500;
            cycle();
            chk("stall_in_ready", u_if.in_ready, 32'd0);
            chk("stall_min",      u_if.res_min,  32'd50);
        end
        u_if.res_ready = 1'b1;
        u_if.in_data   = 16'h1234;
        cycle();
        chk("handshake_in_ready", u_if.in_ready, 32'd1);
        send(16'h40); send(16'h41); send(16'h42); send(16'h43);
        chk_res("after_stall", 16'h40, 16'h43, 0, 4);
        idle(1);

        // reset mid-window
        send(16'd100); send(16'd200);
        rst_n         = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 16'd7;
        cycle();
        u_if.in_valid = 1'b0;
        rst_n         = 1'b1;
        chk("midrst_res_valid", u_if.res_valid, 32'd0);
        chk("midrst_res_max",   u_if.res_max,   32'd0);
        send(16'd1); send(16'hFFFF); send(16'd8); send(16'd0);
        chk_res("after_rst", 0, 16'hFFFF, 0, 4);
        idle(1);

        // flush in IDLE without a sample
        u_if.flush = 1'b1;
        cycle();
        u_if.flush = 1'b0;
        chk("idle_flush_valid", u_if.res_valid, 32'd0);
        idle(1);

        // flush in IDLE with a sample -> single-sample window
        send(16'd77, 1'b1);
        chk_res("idle_flush_sample", 77, 77, 1, 1);
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            u_if.in_valid  = ($urandom_range(0, 3) != 0);
            u_if.in_data   = ($urandom_range(0, 1) == 0) ? WS'($urandom_range(0, 3))
                                                         : WS'($urandom);
            u_if.flush     = ($urandom_range(0, 7) == 0);
            u_if.res_ready = ($urandom_range(0, 1) == 0);
            rst_n          = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_minmax_tracker
